// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the I2C temperature-sensor responder.
//   state_e  : protocol state of the responder FSM
//   REG_*    : register indices selected by the pointer byte
//   ACK/NACK : SDA levels of the acknowledge bit
package i2c_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_e;

    localparam logic REG_TEMP = 1'b0;
    localparam logic REG_CFG  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// Line conditioning for the I2C responder: synchronizes SCL/SDA, optionally
// majority-filters them (macro I2C_GLITCH_FILTER_EN), and produces registered
// one-cycle pulses for SCL rise/fall and START/STOP, plus the SDA level
// aligned with those pulses.
//   clk, reset_n        : system clock, async active-low reset
//   scl_i, sda_i        : raw pad levels
//   scl_rise, scl_fall  : SCL edge pulses
//   start_det, stop_det : START / STOP condition pulses
//   sda_smp             : conditioned SDA, aligned with the pulses
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_smp
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_c, sda_c;
    logic scl_prev_q, sda_prev_q;
    logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic start_q, start_d, stop_q, stop_d, sda_smp_q;

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};

`ifdef I2C_GLITCH_FILTER_EN
    // Two samples of history plus the current one; a level change must be
    // seen on two consecutive clocks, so single-cycle pulses never pass.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;

    assign scl_hist_d = {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
    assign sda_hist_d = {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
    assign scl_flt_d  = maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
    assign sda_flt_d  = maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_flt_q  <= scl_flt_d;
            sda_flt_q  <= sda_flt_d;
        end
    end

    assign scl_c = scl_flt_q;
    assign sda_c = sda_flt_q;
`else
    assign scl_c = scl_sync_q[SYNC_STAGES-1];
    assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        scl_rise_d = scl_c & ~scl_prev_q;
        scl_fall_d = ~scl_c & scl_prev_q;
        // SDA may only change with SCL low; a change with SCL held high on
        // both samples is a bus condition.
        start_d    = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
        stop_d     = scl_c & scl_prev_q & ~sda_prev_q & sda_c;
    end

    // Lines reset to the idle-high bus level so release never looks like START.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_smp_q  <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_c;
            sda_prev_q <= sda_c;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            sda_smp_q  <= sda_c;
        end
    end

    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign sda_smp   = sda_smp_q;

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target emulating the board temperature sensor. Register 0 is the
// read-only temperature (sampled from temp_in at the start of each read
// byte), register 1 a read/write configuration byte. The first write byte
// after the address selects the register pointer (bit 0).
// Optional macro I2C_GLITCH_FILTER_EN enables a 3-sample majority filter in
// the line conditioner.
//   clk, reset_n : system clock (>=16x SCL), async active-low reset
//   scl_i, sda_i : pad levels; sda_oe=1 pulls SDA low (open drain)
//   temp_in      : temperature, two's complement degrees C
//   cfg_out      : configuration register
//   busy         : set on own-address ACK, cleared on STOP/START/IGNORE
//   addr_hit     : one-cycle pulse when own address is ACKed
module i2c_temp_responder
    import i2c_resp_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] temp_in,
    output logic [7:0] cfg_out,
    output logic       busy,
    output logic       addr_hit
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_smp;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_smp   (sda_smp)
    );

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shreg_q, shreg_d;
    logic [7:0] tx_q, tx_d, cfg_q, cfg_d;
    logic       ptr_q, ptr_d, first_q, first_d, rw_q, rw_d;
    logic       ack_seen_q, ack_seen_d;
    logic       sda_oe_q, sda_oe_d, busy_q, busy_d, addr_hit_q, addr_hit_d;
    logic [7:0] rx_byte, rd_load;

    assign rx_byte = {shreg_q, sda_smp};
    assign rd_load = (ptr_q == REG_CFG) ? cfg_q : temp_in;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        cfg_d      = cfg_q;
        ptr_d      = ptr_q;
        first_d    = first_q;
        rw_d       = rw_q;
        ack_seen_d = ack_seen_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        addr_hit_d = 1'b0;

        // Bus conditions take priority over any SCL edge in the same cycle.
        if (start_det) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = 3'd0;
            ack_seen_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shreg_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (rx_byte[7:1] == ADDR) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = rx_byte[0];
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // First SCL fall starts driving ACK; the second ends it.
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d   = ~ACK;
                        addr_hit_d = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d  = ST_RD_DATA;
                            tx_d     = rd_load;
                            sda_oe_d = ~rd_load[7];
                        end else begin
                            state_d  = ST_WR_DATA;
                            first_d  = 1'b1;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    shreg_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_WR_ACK;
                        if (first_q) begin
                            ptr_d   = rx_byte[0];
                            first_d = 1'b0;
                        end else if (ptr_q == REG_CFG) begin
                            cfg_d = rx_byte;
                        end
                    end
                end
                ST_WR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = ~ACK;
                    end else begin
                        sda_oe_d  = 1'b0;
                        state_d   = ST_WR_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                // bit_cnt counts SCL rises already consumed by the master,
                // so the bit to present after a fall is 7 - bit_cnt.
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_q == 3'd7) begin
                            state_d    = ST_RD_ACK;
                            ack_seen_d = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~tx_q[3'd7 - bit_cnt_q];
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_smp == NACK) begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end else begin
                            ack_seen_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (ack_seen_q) begin
                            state_d    = ST_RD_DATA;
                            bit_cnt_d  = 3'd0;
                            ack_seen_d = 1'b0;
                            tx_d       = rd_load;
                            sda_oe_d   = ~rd_load[7];
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 7'd0;
            tx_q       <= 8'h00;
            cfg_q      <= 8'h00;
            ptr_q      <= REG_TEMP;
            first_q    <= 1'b0;
            rw_q       <= 1'b0;
            ack_seen_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            addr_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            cfg_q      <= cfg_d;
            ptr_q      <= ptr_d;
            first_q    <= first_d;
            rw_q       <= rw_d;
            ack_seen_q <= ack_seen_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            addr_hit_q <= addr_hit_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign cfg_out  = cfg_q;
    assign busy     = busy_q;
    assign addr_hit = addr_hit_q;

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Bench for i2c_temp_responder: a bus-functional I2C master drives the
// open-drain bus; expected values go into a queue as stimulus is issued and
// a monitor process compares them with what the master observed on the bus.
module tb_i2c_temp_responder;

    typedef struct {
        string      name;
        logic [7:0] val;
    } item_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] temp_in = 8'h19;
    logic       sda_oe, busy, addr_hit;
    logic [7:0] cfg_out;
    logic       sda_bus;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_temp_responder #(.ADDR(7'h48), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_i    (scl_m),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .temp_in  (temp_in),
        .cfg_out  (cfg_out),
        .busy     (busy),
        .addr_hit (addr_hit)
    );

    item_t exp_q[$];
    item_t obs_q[$];
    int    checks = 0;
    int    errors = 0;
    int    hit_cnt = 0;
    int    busy_cyc = 0;
    logic  hit_prev = 1'b0;
    logic  done = 1'b0;
    logic  final_done = 1'b0;

    // Monitor: pulse-shape checks on addr_hit and scoreboard comparison.
    always @(negedge clk) begin
        item_t o, e;
        if (busy) busy_cyc++;
        if (addr_hit) begin
            hit_cnt++;
            checks++;
            if (!sda_oe || hit_prev) begin
                errors++;
                $display("FAIL addr_hit_pulse: sda_oe=%0b prev_hit=%0b, required sda_oe=1 prev_hit=0",
                         sda_oe, hit_prev);
            end
        end
        hit_prev = addr_hit;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s: got %h, no expected value queued", o.name, o.val);
            end else begin
                e = exp_q.pop_front();
                if (e.name != o.name || e.val !== o.val) begin
                    errors++;
                    $display("FAIL %s: got %h (%s), required %h", e.name, o.val, o.name, e.val);
                end
            end
        end
        if (done && !final_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations unmatched, required 0", exp_q.size());
            end
            final_done = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic expect_v(input string nm, input logic [7:0] v);
        exp_q.push_back('{name: nm, val: v});
    endtask

    task automatic observe(input string nm, input logic [7:0] v);
        obs_q.push_back('{name: nm, val: v});
    endtask

    task automatic check_now(input string nm, input logic [7:0] act, input logic [7:0] req);
        expect_v(nm, req);
        observe(nm, act);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(8);
        scl_m = 1'b1; tick(8);
        sda_m = 1'b0; tick(8);
        scl_m = 1'b0; tick(8);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(8);
        scl_m = 1'b1; tick(8);
        sda_m = 1'b1; tick(16);
    endtask

    // glitch=1 inserts a one-clock SCL high pulse during the low phase.
    task automatic send_bit(input logic b, input logic glitch);
        sda_m = b;
        if (glitch) begin
            tick(4); scl_m = 1'b1; tick(1); scl_m = 1'b0; tick(3);
        end else begin
            tick(8);
        end
        scl_m = 1'b1; tick(16);
        scl_m = 1'b0; tick(8);
    endtask

    task automatic recv_bit(output logic v);
        sda_m = 1'b1; tick(8);
        scl_m = 1'b1; tick(8);
        @(negedge clk) v = sda_bus;
        tick(8);
        scl_m = 1'b0; tick(8);
    endtask

    task automatic write_byte(input string nm, input logic [7:0] b, input logic exp_ack,
                              input logic glitch);
        logic a;
        expect_v(nm, {7'd0, exp_ack});
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch);
        recv_bit(a);
        observe(nm, {7'd0, a});
    endtask

    task automatic read_byte(input string nm, input logic [7:0] exp_b, input logic m_ack,
                             input logic [7:0] next_temp);
        logic [7:0] r;
        logic       v;
        expect_v(nm, exp_b);
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            recv_bit(v);
            r = {r[6:0], v};
        end
        observe(nm, r);
        temp_in = next_temp;
        send_bit(m_ack, 1'b0);
    endtask

    initial begin
        int h0, b0;
        tick(3);
        @(negedge clk);
        check_now("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
        check_now("rst_cfg", cfg_out, 8'h00);
        check_now("rst_busy", {7'd0, busy}, 8'h00);
        check_now("rst_addr_hit", {7'd0, addr_hit}, 8'h00);
        reset_n = 1'b1;
        tick(10);

        // Write pointer=1 then 0xA5 into cfg.
        h0 = hit_cnt;
        i2c_start();
        write_byte("t1_addr_ack", 8'h90, 1'b0, 1'b0);
        check_now("t1_busy_on", {7'd0, busy}, 8'h01);
        write_byte("t1_ptr_ack", 8'h01, 1'b0, 1'b0);
        write_byte("t1_data_ack", 8'hA5, 1'b0, 1'b0);
        i2c_stop();
        check_now("t1_cfg", cfg_out, 8'hA5);
        check_now("t1_busy_off", {7'd0, busy}, 8'h00);
        check_now("t1_hits", 8'(hit_cnt - h0), 8'h01);

        // Pointer=0, repeated START, read temperature with NACK.
        temp_in = 8'h19;
        i2c_start();
        write_byte("t2_addr_ack", 8'h90, 1'b0, 1'b0);
        write_byte("t2_ptr_ack", 8'h00, 1'b0, 1'b0);
        i2c_start();
        write_byte("t2_raddr_ack", 8'h91, 1'b0, 1'b0);
        read_byte("t2_rd", 8'h19, 1'b1, 8'h19);
        check_now("t2_sda_rel", {7'd0, sda_oe}, 8'h00);
        check_now("t2_busy_ign", {7'd0, busy}, 8'h00);
        read_byte("t2_ign_rd", 8'hFF, 1'b1, 8'h19);
        i2c_stop();

        // Three-byte read; temperature changes before the second byte.
        i2c_start();
        write_byte("t3_addr_ack", 8'h91, 1'b0, 1'b0);
        read_byte("t3_rd0", 8'h19, 1'b0, 8'h1A);
        read_byte("t3_rd1", 8'h1A, 1'b0, 8'h1A);
        read_byte("t3_rd2", 8'h1A, 1'b1, 8'h1A);
        i2c_stop();

        // Foreign address: no ACK, no busy, no hit; then own address works.
        h0 = hit_cnt;
        b0 = busy_cyc;
        i2c_start();
        write_byte("t4_foreign_nack", 8'hA0, 1'b1, 1'b0);
        check_now("t4_hits", 8'(hit_cnt - h0), 8'h00);
        check_now("t4_busy_cyc", 8'(busy_cyc - b0), 8'h00);
        i2c_start();
        write_byte("t4_own_ack", 8'h91, 1'b0, 1'b0);
        read_byte("t4_rd", 8'h1A, 1'b1, 8'h1A);
        i2c_stop();

        // Reset while the DUT drives ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(tick_byte(i), 1'b0);
        sda_m = 1'b1;
        tick(8);
        @(negedge clk);
        check_now("t5_ack_drv", {7'd0, sda_oe}, 8'h01);
        reset_n = 1'b0;
        #1;
        check_now("t5_rst_sda_oe", {7'd0, sda_oe}, 8'h00);
        check_now("t5_rst_cfg", cfg_out, 8'h00);
        tick(3);
        reset_n = 1'b1;
        tick(4);
        i2c_stop();
        i2c_start();
        write_byte("t5_addr_ack", 8'h90, 1'b0, 1'b0);
        write_byte("t5_ptr_ack", 8'h01, 1'b0, 1'b0);
        write_byte("t5_data_ack", 8'h3C, 1'b0, 1'b0);
        i2c_stop();
        check_now("t5_cfg", cfg_out, 8'h3C);
        i2c_start();
        write_byte("t5_raddr_ack", 8'h91, 1'b0, 1'b0);
        read_byte("t5_rd_cfg", 8'h3C, 1'b1, 8'h1A);
        i2c_stop();

`ifdef I2C_GLITCH_FILTER_EN
        // One-clock SCL glitches in every low phase must be rejected.
        i2c_start();
        write_byte("t6_addr_ack", 8'h90, 1'b0, 1'b1);
        write_byte("t6_ptr_ack", 8'h01, 1'b0, 1'b1);
        write_byte("t6_data_ack", 8'h5A, 1'b0, 1'b1);
        i2c_stop();
        check_now("t6_cfg", cfg_out, 8'h5A);
`endif

        done = 1'b1;
        for (int i = 0; i < 100 && !final_done; i++) @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Address byte 0x90 (0x48, write) used for the reset-during-ACK case.
    function automatic logic tick_byte(input int i);
        logic [7:0] b;
        b = 8'h90;
        return b[i];
    endfunction

endmodule

// File: doc/i2c_temp_responder.md
# i2c_temp_responder

I2C target (responder) emulating the on-board temperature sensor, the far end of the I2C master driving `sda`/`scl` in the sensor subsystem. Lets the master's read/write path and seven-segment display chain be exercised in simulation and on hardware without the physical sensor. Exposes one read-only temperature register fed from a parallel input and one read/write configuration register.

## Interface
- `ADDR`, 7'h48, 7-bit target address matched after START.
- `SYNC_STAGES`, 2, flip-flop stages on `scl_i`/`sda_i` (min 2).
- `clk`  input  1  system clock; must be ≥16× the SCL rate.
- `reset_n`  input  1  asynchronous, active-low reset.
- `scl_i`  input  1  SCL pad level (never driven).
- `sda_i`  input  1  SDA pad level.
- `sda_oe`  output  1  1 = pull SDA low (open-drain); 0 = release.
- `temp_in`  input  8  current temperature, two's complement °C.
- `cfg_out`  output  8  configuration register contents.
- `busy`  output  1  high from address match to STOP/START/NACK.
- `addr_hit`  output  1  one-cycle pulse when own address is ACKed.

## Operation
- Line conditioning: synchronize SCL/SDA; SCL rise/fall edges from synchronized SCL; START = SDA fall with SCL high, STOP = SDA rise with SCL high.
- Data sampled on SCL rise; `sda_oe` changes only on SCL fall (except reset/STOP/START release).
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE→ADDR on START. ADDR shifts 8 bits MSB first (bit counter 0–7); on match→ADDR_ACK (drive low one SCL period, pulse `addr_hit`), else→IGNORE (no drive).
- ADDR_ACK→WR_DATA if R/W=0, RD_DATA if R/W=1.
- WR_DATA: first byte after address loads pointer (bit0 only; 0=temp, 1=cfg); later bytes write `cfg_out` if pointer=1, discarded if pointer=0. Every byte ACKed (WR_ACK), then back to WR_DATA.
- RD_DATA: shift out reg[pointer] MSB first; bit=0 → `sda_oe`=1, bit=1 → release. Pointer does not auto-increment.
- RD_ACK: sample master bit on SCL rise; ACK(0)→RD_DATA with fresh byte, NACK(1)→IGNORE.
- Temperature byte captured from `temp_in` at the SCL fall that starts each read byte; stable for that byte.
- START in any state → ADDR (repeated start); pointer retained. STOP in any state → IDLE, SDA released.
- `busy` set with `addr_hit`; cleared on STOP, START, entering IGNORE.

## Timing
- Reset values: `sda_oe`=0, `cfg_out`=8'h00, `busy`=0, `addr_hit`=0, pointer=0, state IDLE.
- Pad-to-detect latency: SYNC_STAGES+1 clk cycles (+2 with filter).
- `sda_oe` updates on the clk edge after detected SCL fall; `cfg_out` updates on the clk edge after the 8th bit's SCL rise.
- `addr_hit` high exactly one clk cycle, coincident with `sda_oe` going 1 for ACK.
- Reset mid-transfer: `sda_oe` drops to 0 asynchronously; `cfg_out` returns to 8'h00.
- START and SCL edge in same cycle: START wins.

## Configuration
- `I2C_GLITCH_FILTER_EN`: defined → 3-sample majority filter on each synchronized line after the synchronizer, adding 2 clk latency and rejecting pulses ≤1 clk. Undefined → synchronizer output used directly.

## Structure
- Package `i2c_resp_pkg`: state enum, register indices (`REG_TEMP`=0, `REG_CFG`=1), ACK/NACK constants.
- Sub-module `i2c_line_cond`: synchronizers, optional filter, SCL edge and START/STOP detection.

## Test plan
- Write 0x48/W, 0x01, 0xA5, STOP → three ACKs, `cfg_out`=8'hA5, `addr_hit` one pulse, `busy` low after STOP.
- Write 0x48/W, 0x00, repeated START, 0x48/R with `temp_in`=8'h19, master NACK → byte read 0x19, SDA released, IGNORE until STOP.
- Read 3 bytes with ACK,ACK,NACK while `temp_in` changes 0x19→0x1A between bytes → reads 0x19, 0x1A, 0x1A.
- Address 0x50/W → no ACK (SDA stays high), `busy`/`addr_hit` stay 0, next START to 0x48 works.
- Assert `reset_n`=0 while driving ACK low → `sda_oe`=0 immediately, `cfg_out`=0; next transaction normal.
- With `I2C_GLITCH_FILTER_EN`: 1-cycle SCL glitch mid-byte → ignored, byte received correctly.
